// File: rtl/neighbor_info_cntl_p.sv
// Neighbor-info memory controller.
// Preloads NUM_BANKS single-port SRAM banks from per-bank serial streams framed
// by sos/eos, then serves node-ID lookups one per cycle. Each lookup reads the
// bank/half picked by the replay iteration. A 2-entry output buffer absorbs
// downstream back-pressure.
module neighbor_info_cntl_p #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 16,
  parameter int NODE_ID_W = 8,
  parameter int ADDR_W    = NODE_ID_W + 1,
  parameter int PE_TAG_W  = 2,
  parameter int ITER_W    = $clog2(NUM_BANKS) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ITER_W-1:0]           cur_iter,
  input  logic                        req_valid,
  input  logic [NODE_ID_W-1:0]        req_node_id,
  input  logic [PE_TAG_W-1:0]         req_pe_tag,
  output logic                        req_ready,
  output logic                        resp_valid,
  output logic [DATA_W-1:0]           resp_addr,
  output logic [PE_TAG_W-1:0]         resp_pe_tag,
  input  logic                        resp_ready,
  input  logic                        sos,
  input  logic                        eos,
  input  logic [NUM_BANKS-1:0]        ser_data,
  output logic [NUM_BANKS-1:0]        sram_cen,
  output logic [NUM_BANKS-1:0]        sram_wen,
  output logic [NUM_BANKS*ADDR_W-1:0] sram_a,
  output logic [NUM_BANKS*DATA_W-1:0] sram_d,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_q,
  output logic                        preload_done,
  output logic                        overflow
);

  localparam int BANK_W = ITER_W - 1;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic {IDLE = 1'b0, PRELOAD = 1'b1} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [ADDR_W:0]        wr_addr;
  logic [DATA_W-1:0]      shreg [NUM_BANKS];
  logic                   word_done;
  logic                   wr_en;

  logic                   vld_p0;
  logic [BANK_W-1:0]      bank_p0;
  logic [ADDR_W-1:0]      addr_p0;

  logic                   vld_p1;
  logic [BANK_W-1:0]      bank_p1;
  logic [PE_TAG_W-1:0]    tag_p1;
  logic [DATA_W-1:0]      q_p1;

  logic [1:0]             occ;
  logic [DATA_W-1:0]      obuf_addr [2];
  logic [PE_TAG_W-1:0]    obuf_tag  [2];
  logic                   pop;
  logic [2:0]             slots_used;

  // Append one serial bit (MSB first) to a partially assembled word.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                  input logic b);
    return {w[DATA_W-2:0], b};
  endfunction

  // Stage p0: request accept and SRAM read issue
  assign resp_valid = (occ != 2'd0);
  assign pop        = resp_valid && resp_ready;
  // A slot freed by a same-cycle pop counts as free, so a steady stream with
  // resp_ready held high sustains one lookup per cycle.
  assign slots_used = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
  assign req_ready  = reset && (state == IDLE) && !sos && (slots_used < 3'd2);
  assign vld_p0     = req_valid && req_ready;
  assign bank_p0    = cur_iter[ITER_W-1:1];
  assign addr_p0    = {cur_iter[0], req_node_id};

  // A complete word is ready on the cycle its last bit is on ser_data.
  assign word_done  = (state == PRELOAD) && !sos && (bit_cnt == CNT_W'(DATA_W - 1));
  assign wr_en      = word_done && !wr_addr[ADDR_W];

  // Drive the SRAM ports: preload writes hit every bank, lookups one bank.
  always_comb begin
    sram_cen = '1;
    sram_wen = '1;
    sram_a   = '0;
    sram_d   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (wr_en) begin
        sram_cen[k] = 1'b0;
        sram_wen[k] = 1'b0;
        sram_a[k*ADDR_W +: ADDR_W] = wr_addr[ADDR_W-1:0];
        sram_d[k*DATA_W +: DATA_W] = shift_in(shreg[k], ser_data[k]);
      end else if (vld_p0 && (bank_p0 == BANK_W'(k))) begin
        sram_cen[k] = 1'b0;
        sram_a[k*ADDR_W +: ADDR_W] = addr_p0;
      end
    end
  end

  // Carry the bank and tag of an issued read alongside its valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      bank_p1 <= '0;
      tag_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        bank_p1 <= bank_p0;
        tag_p1  <= req_pe_tag;
      end
    end
  end

  // Stage p1: read data return from the bank chosen at accept time
  always_comb begin
    q_p1 = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank_p1 == BANK_W'(k)) q_p1 = sram_q[k*DATA_W +: DATA_W];
    end
  end

  // Stage p2: in-order 2-entry output buffer, entry 0 is the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ          <= 2'd0;
      obuf_addr[0] <= '0;
      obuf_addr[1] <= '0;
      obuf_tag[0]  <= '0;
      obuf_tag[1]  <= '0;
    end else begin
      case ({vld_p1, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            obuf_addr[0] <= q_p1;
            obuf_tag[0]  <= tag_p1;
          end else begin
            obuf_addr[1] <= q_p1;
            obuf_tag[1]  <= tag_p1;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          obuf_addr[0] <= obuf_addr[1];
          obuf_tag[0]  <= obuf_tag[1];
          occ          <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            obuf_addr[0] <= q_p1;
            obuf_tag[0]  <= tag_p1;
          end else begin
            obuf_addr[0] <= obuf_addr[1];
            obuf_tag[0]  <= obuf_tag[1];
            obuf_addr[1] <= q_p1;
            obuf_tag[1]  <= tag_p1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_addr   = obuf_addr[0];
  assign resp_pe_tag = obuf_tag[0];

  // Control FSM: serial preload framing, write address, done/overflow flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      wr_addr      <= '0;
      preload_done <= 1'b0;
      overflow     <= 1'b0;
      for (int k = 0; k < NUM_BANKS; k++) shreg[k] <= '0;
    end else begin
      preload_done <= 1'b0;
      if (word_done && wr_addr[ADDR_W]) overflow <= 1'b1;
      if (sos) begin
        // Start or restart: earlier SRAM contents are left in place.
        state   <= PRELOAD;
        bit_cnt <= '0;
        wr_addr <= '0;
        for (int k = 0; k < NUM_BANKS; k++) shreg[k] <= '0;
      end else if (state == PRELOAD) begin
        for (int k = 0; k < NUM_BANKS; k++) shreg[k] <= shift_in(shreg[k], ser_data[k]);
        if (eos) begin
          state        <= IDLE;
          bit_cnt      <= '0;
          wr_addr      <= '0;
          preload_done <= 1'b1;
        end else begin
          bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
          if (wr_en) wr_addr <= wr_addr + (ADDR_W+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_neighbor_info_cntl_p.sv
// Self-checking bench for neighbor_info_cntl_p: default-size instance for
// preload/lookup scenarios, plus a tiny-address instance for overflow.
module tb_neighbor_info_cntl_p;

  localparam int NB  = 4;
  localparam int DW  = 16;
  localparam int NW  = 8;
  localparam int AW  = 9;
  localparam int TW  = 2;
  localparam int IW  = 3;
  localparam int AW1 = 2;

  typedef struct { int bank; int addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [DW-1:0] addr; logic [TW-1:0] tag; } rsp_t;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [IW-1:0]   cur_iter;
  logic            req_valid;
  logic [NW-1:0]   req_node_id;
  logic [TW-1:0]   req_pe_tag;
  logic            req_ready;
  logic            resp_valid;
  logic [DW-1:0]   resp_addr;
  logic [TW-1:0]   resp_pe_tag;
  logic            resp_ready;
  logic            sos, eos, sel1;
  logic            sos0, sos1;
  logic [NB-1:0]   ser_data;
  logic [NB-1:0]   sram_cen, sram_wen;
  logic [NB*AW-1:0] sram_a;
  logic [NB*DW-1:0] sram_d, sram_q;
  logic            preload_done, overflow;

  logic            req_ready1, resp_valid1, preload_done1, overflow1;
  logic [DW-1:0]   resp_addr1;
  logic [TW-1:0]   resp_pe_tag1;
  logic [NB-1:0]   sram_cen1, sram_wen1;
  logic [NB*AW1-1:0] sram_a1;
  logic [NB*DW-1:0] sram_d1, sram_q1;

  assign sos0    = sos & ~sel1;
  assign sos1    = sos & sel1;
  assign sram_q1 = '0;

  neighbor_info_cntl_p dut (
    .clk(clk), .reset(reset), .cur_iter(cur_iter), .req_valid(req_valid),
    .req_node_id(req_node_id), .req_pe_tag(req_pe_tag), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_pe_tag(resp_pe_tag),
    .resp_ready(resp_ready), .sos(sos0), .eos(eos), .ser_data(ser_data),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q), .preload_done(preload_done), .overflow(overflow)
  );

  neighbor_info_cntl_p #(.NODE_ID_W(1)) dut1 (
    .clk(clk), .reset(reset), .cur_iter(3'd0), .req_valid(1'b0),
    .req_node_id(1'b0), .req_pe_tag(2'd0), .req_ready(req_ready1),
    .resp_valid(resp_valid1), .resp_addr(resp_addr1), .resp_pe_tag(resp_pe_tag1),
    .resp_ready(1'b1), .sos(sos1), .eos(eos), .ser_data(ser_data),
    .sram_cen(sram_cen1), .sram_wen(sram_wen1), .sram_a(sram_a1), .sram_d(sram_d1),
    .sram_q(sram_q1), .preload_done(preload_done1), .overflow(overflow1)
  );

  // SRAM model for the main instance: 1-cycle read latency.
  logic [DW-1:0] mem0 [NB][512];
  initial begin
    for (int k = 0; k < NB; k++)
      for (int a = 0; a < 512; a++) mem0[k][a] <= 16'($urandom);
    sram_q <= '0;
  end
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (sram_cen[k] === 1'b0) begin
        if (sram_wen[k] === 1'b0) mem0[k][sram_a[k*AW +: AW]] <= sram_d[k*DW +: DW];
        else sram_q[k*DW +: DW] <= mem0[k][sram_a[k*AW +: AW]];
      end
    end
  end

  // Observers: write logs, response log, preload_done pulse count.
  wr_t  wlog0[$];
  wr_t  wlog1[$];
  rsp_t rlog[$];
  rsp_t exq[$];
  int   pd_cnt = 0;
  logic [DW-1:0] pw [NB][8];

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      for (int k = 0; k < NB; k++) begin
        if (sram_cen[k] === 1'b0 && sram_wen[k] === 1'b0)
          wlog0.push_back('{k, int'(sram_a[k*AW +: AW]), sram_d[k*DW +: DW]});
        if (sram_cen1[k] === 1'b0 && sram_wen1[k] === 1'b0)
          wlog1.push_back('{k, int'(sram_a1[k*AW1 +: AW1]), sram_d1[k*DW +: DW]});
      end
      if (resp_valid === 1'b1 && resp_ready === 1'b1)
        rlog.push_back('{resp_addr, resp_pe_tag});
      if (preload_done === 1'b1) pd_cnt <= pd_cnt + 1;
    end
  end

  // Reference: a lookup returns the word stored at {half, node} of bank iter/2.
  function automatic rsp_t model_rsp(input logic [IW-1:0] it, input logic [NW-1:0] node,
                                     input logic [TW-1:0] tag);
    rsp_t r;
    r.addr = mem0[it[IW-1:1]][{it[0], node}];
    r.tag  = tag;
    return r;
  endfunction

  task automatic idle_inputs();
    cur_iter = '0; req_valid = 1'b0; req_node_id = '0; req_pe_tag = '0;
    resp_ready = 1'b1; sos = 1'b0; eos = 1'b0; ser_data = '0;
  endtask

  task automatic start_sos();
    @(negedge clk); sos = 1'b1;
    @(negedge clk); sos = 1'b0;
  endtask

  // Stream nw words plus tail bits of pw, MSB first; optional eos on final bit.
  task automatic stream(input int nw, input int tail, input bit do_eos);
    int total;
    total = nw * DW + tail;
    for (int i = 0; i < total; i++) begin
      for (int k = 0; k < NB; k++) ser_data[k] = pw[k][i / DW][DW - 1 - (i % DW)];
      eos = do_eos && (i == total - 1);
      @(negedge clk);
    end
    eos = 1'b0;
    ser_data = '0;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && rlog.size() < exq.size(); c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_responses(input string name);
    checks++;
    if (rlog.size() != exq.size()) begin
      failures++;
      $display("FAIL %s count: got %0d responses, expected %0d", name, rlog.size(), exq.size());
    end
    for (int i = 0; i < exq.size() && i < rlog.size(); i++) begin
      checks++;
      if (rlog[i].addr !== exq[i].addr || rlog[i].tag !== exq[i].tag) begin
        failures++;
        $display("FAIL %s resp[%0d]: got addr=%h tag=%0d, expected addr=%h tag=%0d",
                 name, i, rlog[i].addr, rlog[i].tag, exq[i].addr, exq[i].tag);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sel1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cur_iter = 3'($urandom); req_valid = 1'($urandom); req_node_id = 8'($urandom);
      req_pe_tag = 2'($urandom); resp_ready = 1'($urandom); sos = 1'($urandom);
      eos = 1'($urandom); ser_data = 4'($urandom);
      @(negedge clk);
      checks++;
      if ({req_ready, resp_valid, preload_done, overflow} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_flags: got ready/valid/done/ovf=%b expected 0000",
                 {req_ready, resp_valid, preload_done, overflow});
      end
      checks++;
      if (resp_addr !== '0 || resp_pe_tag !== '0) begin
        failures++;
        $display("FAIL reset_resp: got addr=%h tag=%0d expected 0", resp_addr, resp_pe_tag);
      end
      checks++;
      if (sram_cen !== 4'b1111 || sram_wen !== 4'b1111) begin
        failures++;
        $display("FAIL reset_cen_wen: got cen=%b wen=%b expected 1111", sram_cen, sram_wen);
      end
      checks++;
      if (sram_a !== '0 || sram_d !== '0) begin
        failures++;
        $display("FAIL reset_a_d: got a=%h d=%h expected 0", sram_a, sram_d);
      end
    end
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_preload();
    int pd0;
    sel1 = 1'b0;
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 2; j++) pw[k][j] = 16'(32'hA000 + 16 * k + j);
    wlog0.delete();
    pd0 = pd_cnt;
    start_sos();
    stream(2, 0, 1'b1);
    checks++;
    if (preload_done !== 1'b1) begin
      failures++;
      $display("FAIL preload_done_pulse: got %b expected 1", preload_done);
    end
    @(negedge clk);
    checks++;
    if (preload_done !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL preload_exit: got done=%b ready=%b expected done=0 ready=1",
               preload_done, req_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pd_cnt - pd0 != 1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL preload_done_count: got pulses=%0d ovf=%b expected 1 and 0",
               pd_cnt - pd0, overflow);
    end
    checks++;
    if (wlog0.size() != 8) begin
      failures++;
      $display("FAIL preload_writes: got %0d writes expected 8", wlog0.size());
    end
    for (int i = 0; i < 8 && i < wlog0.size(); i++) begin
      checks++;
      if (wlog0[i].bank != i % 4 || wlog0[i].addr != i / 4 ||
          wlog0[i].data !== 16'(32'hA000 + 16 * (i % 4) + i / 4)) begin
        failures++;
        $display("FAIL preload_write[%0d]: got bank=%0d addr=%0d data=%h expected bank=%0d addr=%0d data=%h",
                 i, wlog0[i].bank, wlog0[i].addr, wlog0[i].data, i % 4, i / 4,
                 16'(32'hA000 + 16 * (i % 4) + i / 4));
      end
    end
  endtask

  task automatic test_lookup();
    logic [DW-1:0] expv;
    @(negedge clk);
    resp_ready = 1'b1; cur_iter = 3'b101; req_node_id = 8'h12; req_pe_tag = 2'd2; req_valid = 1'b1;
    #1;
    expv = mem0[2][9'h112];
    checks++;
    if (req_ready !== 1'b1 || sram_cen !== 4'b1011 || sram_wen !== 4'b1111) begin
      failures++;
      $display("FAIL lookup_issue: got ready=%b cen=%b wen=%b expected 1 1011 1111",
               req_ready, sram_cen, sram_wen);
    end
    checks++;
    if (sram_a[2*AW +: AW] !== 9'h112) begin
      failures++;
      $display("FAIL lookup_addr: got %h expected 112", sram_a[2*AW +: AW]);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lookup_early: got resp_valid=%b expected 0", resp_valid);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_addr !== expv || resp_pe_tag !== 2'd2) begin
      failures++;
      $display("FAIL lookup_resp: got v=%b addr=%h tag=%0d expected v=1 addr=%h tag=2",
               resp_valid, resp_addr, resp_pe_tag, expv);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lookup_once: got resp_valid=%b expected 0", resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] it [5];
    logic [NW-1:0] nd [5];
    logic [TW-1:0] tg [5];
    int acc = 0;
    int cyc = 0;
    for (int i = 0; i < 5; i++) begin
      it[i] = 3'($urandom); nd[i] = 8'($urandom); tg[i] = 2'($urandom);
    end
    rlog.delete(); exq.delete();
    resp_ready = 1'b0;
    while (acc < 5 && cyc < 60) begin
      @(negedge clk);
      if (cyc == 8) resp_ready = 1'b1;
      req_valid = 1'b1; cur_iter = it[acc]; req_node_id = nd[acc]; req_pe_tag = tg[acc];
      #1;
      if (cyc == 7) begin
        checks++;
        if (acc != 2 || req_ready !== 1'b0) begin
          failures++;
          $display("FAIL backpressure_stall: got accepts=%0d ready=%b expected 2 and 0", acc, req_ready);
        end
      end
      if (req_ready) begin
        exq.push_back(model_rsp(it[acc], nd[acc], tg[acc]));
        acc++;
      end
      cyc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (acc != 5) begin
      failures++;
      $display("FAIL backpressure_accepts: got %0d expected 5", acc);
    end
    drain(40);
    compare_responses("backpressure");
  endtask

  task automatic test_throughput();
    int stalls = 0;
    rlog.delete(); exq.delete();
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b1; cur_iter = 3'($urandom); req_node_id = 8'($urandom); req_pe_tag = 2'($urandom);
      #1;
      if (req_ready !== 1'b1) stalls++;
      else exq.push_back(model_rsp(cur_iter, req_node_id, req_pe_tag));
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (stalls != 0) begin
      failures++;
      $display("FAIL throughput_stalls: got %0d stall cycles expected 0", stalls);
    end
    drain(40);
    compare_responses("throughput");
  endtask

  task automatic test_random_traffic();
    int acc = 0;
    int cyc = 0;
    rlog.delete(); exq.delete();
    while (acc < 30 && cyc < 500) begin
      @(negedge clk);
      resp_ready = ($urandom_range(0, 3) != 0);
      req_valid = 1'($urandom); cur_iter = 3'($urandom);
      req_node_id = 8'($urandom); req_pe_tag = 2'($urandom);
      #1;
      if (req_valid && req_ready) begin
        exq.push_back(model_rsp(cur_iter, req_node_id, req_pe_tag));
        acc++;
      end
      cyc++;
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    checks++;
    if (acc != 30) begin
      failures++;
      $display("FAIL random_accepts: got %0d expected 30", acc);
    end
    drain(40);
    compare_responses("random");
  endtask

  task automatic test_sos_after_accept_eos_midword();
    rlog.delete(); exq.delete(); wlog0.delete();
    sel1 = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < NB; k++) for (int j = 0; j < 2; j++) pw[k][j] = 16'($urandom);
    @(negedge clk);
    req_valid = 1'b1; cur_iter = 3'($urandom); req_node_id = 8'($urandom); req_pe_tag = 2'($urandom);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL corner_accept: got ready=%b expected 1", req_ready);
    end
    exq.push_back(model_rsp(cur_iter, req_node_id, req_pe_tag));
    @(negedge clk);
    sos = 1'b1; req_node_id = 8'($urandom);
    #1;
    checks++;
    if (req_ready !== 1'b0 || sram_cen !== 4'b1111) begin
      failures++;
      $display("FAIL corner_sos_priority: got ready=%b cen=%b expected 0 1111", req_ready, sram_cen);
    end
    @(negedge clk);
    sos = 1'b0; req_valid = 1'b0;
    stream(1, 5, 1'b1);
    repeat (2) @(negedge clk);
    compare_responses("corner_inflight");
    checks++;
    if (wlog0.size() != 4) begin
      failures++;
      $display("FAIL corner_partial: got %0d writes expected 4", wlog0.size());
    end
    for (int i = 0; i < 4 && i < wlog0.size(); i++) begin
      checks++;
      if (wlog0[i].bank != i || wlog0[i].addr != 0 || wlog0[i].data !== pw[i][0]) begin
        failures++;
        $display("FAIL corner_word[%0d]: got bank=%0d addr=%0d data=%h expected bank=%0d addr=0 data=%h",
                 i, wlog0[i].bank, wlog0[i].addr, wlog0[i].data, i, pw[i][0]);
      end
    end
  endtask

  task automatic test_sos_restart();
    wlog0.delete();
    sel1 = 1'b0;
    for (int k = 0; k < NB; k++) for (int j = 0; j < 2; j++) pw[k][j] = 16'($urandom);
    start_sos();
    stream(1, 3, 1'b0);
    for (int k = 0; k < NB; k++) pw[k][0] = 16'($urandom);
    start_sos();
    stream(1, 0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (wlog0.size() != 8) begin
      failures++;
      $display("FAIL restart_writes: got %0d writes expected 8", wlog0.size());
    end
    for (int i = 4; i < 8 && i < wlog0.size(); i++) begin
      checks++;
      if (wlog0[i].bank != i - 4 || wlog0[i].addr != 0 || wlog0[i].data !== pw[i-4][0]) begin
        failures++;
        $display("FAIL restart_word[%0d]: got bank=%0d addr=%0d data=%h expected bank=%0d addr=0 data=%h",
                 i, wlog0[i].bank, wlog0[i].addr, wlog0[i].data, i - 4, pw[i-4][0]);
      end
    end
  endtask

  task automatic test_overflow();
    wlog1.delete();
    sel1 = 1'b1;
    for (int k = 0; k < NB; k++) for (int j = 0; j < 5; j++) pw[k][j] = 16'($urandom);
    start_sos();
    stream(5, 0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (wlog1.size() != 16) begin
      failures++;
      $display("FAIL overflow_writes: got %0d writes expected 16", wlog1.size());
    end
    for (int i = 0; i < 16 && i < wlog1.size(); i++) begin
      checks++;
      if (wlog1[i].bank != i % 4 || wlog1[i].addr != i / 4 || wlog1[i].data !== pw[i%4][i/4]) begin
        failures++;
        $display("FAIL overflow_write[%0d]: got bank=%0d addr=%0d data=%h expected bank=%0d addr=%0d data=%h",
                 i, wlog1[i].bank, wlog1[i].addr, wlog1[i].data, i % 4, i / 4, pw[i%4][i/4]);
      end
    end
    checks++;
    if (overflow1 !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_flag: got ovf1=%b ovf0=%b expected 1 and 0", overflow1, overflow);
    end
    wlog1.delete();
    start_sos();
    stream(1, 0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (overflow1 !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: got %b expected 1", overflow1);
    end
    checks++;
    if (wlog1.size() != 4 || (wlog1.size() > 0 && wlog1[0].addr != 0)) begin
      failures++;
      $display("FAIL overflow_rearm: got %0d writes expected 4 at addr 0", wlog1.size());
    end
    sel1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel1 = 1'b0;
    for (int k = 0; k < NB; k++) pw[k][0] = 16'($urandom);
    start_sos();
    stream(0, 10, 1'b0);
    wlog0.delete();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (sram_cen !== 4'b1111 || req_ready !== 1'b0 || overflow1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got cen=%b ready=%b ovf1=%b expected 1111 0 0",
               sram_cen, req_ready, overflow1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sram_cen !== 4'b1111 || sram_wen !== 4'b1111) begin
      failures++;
      $display("FAIL reset_mid_noaccess: got cen=%b wen=%b expected 1111", sram_cen, sram_wen);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_idle: got ready=%b expected 1", req_ready);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ser_data = 4'($urandom);
    end
    ser_data = '0;
    checks++;
    if (wlog0.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_abort: got %0d writes expected 0", wlog0.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_preload();
    test_lookup();
    test_back_to_back();
    test_throughput();
    test_random_traffic();
    test_sos_after_accept_eos_midword();
    test_sos_restart();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
